// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Program-counter and fetch-sequencing stage ahead of the core datapath.
// A one-cycle req pulse starts a program at START_ADDR. While running, the
// PC advances sequentially. The decoder can redirect it with a branch, and
// the datapath can hold it with a stall. A decoder halt ends the program,
// and done then stays high until the next start.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   req            start request (sampled only in IDLE or DONE)
//   halt           decoder: current instruction is a halt
//   stall          datapath: hold the current PC this cycle
//   branch_taken   decoder: redirect the PC this cycle
//   branch_rel     1 = pc + branch_offs, 0 = branch_target
//   branch_offs    signed relative offset (OFFS_W bits)
//   branch_target  absolute target address (PC_W bits)
//   pc             current instruction address, registered
//   fetch_valid    pc holds a live instruction
//   running        state is RUN
//   done           program finished, held until the next start
//   cycle_count    (CYCLE_COUNT_EN only) saturating 16-bit RUN-cycle count
//
// Optional feature macro: CYCLE_COUNT_EN adds the cycle_count output.
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int OFFS_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              halt,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              branch_rel,
    input  logic [OFFS_W-1:0] branch_offs,
    input  logic [PC_W-1:0]   branch_target,
`ifdef CYCLE_COUNT_EN
    output logic [15:0]       cycle_count,
`endif
    output logic [PC_W-1:0]   pc,
    output logic              fetch_valid,
    output logic              running,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t state;

    // Sign-extend the offset to PC width. The add then wraps modulo
    // 2^PC_W, so negative offsets below address 0 wrap to the top.
    logic signed [OFFS_W-1:0] offs_s;
    logic signed [PC_W-1:0]   offs_ext;
    logic [PC_W-1:0]          pc_next;

    assign offs_s   = branch_offs;
    assign offs_ext = PC_W'(offs_s);

    // Next PC while running. Priority is halt, then stall, then branch,
    // then sequential. A stalled branch is dropped; the decoder re-presents it.
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (halt || stall) begin
            pc_next = pc;
        end else if (branch_taken) begin
            pc_next = branch_rel ? (pc + $unsigned(offs_ext)) : branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= START_PC;
            fetch_valid <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
`ifdef CYCLE_COUNT_EN
            cycle_count <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        state       <= RUN;
                        pc          <= START_PC;
                        fetch_valid <= 1'b1;
                        running     <= 1'b1;
                        done        <= 1'b0;
`ifdef CYCLE_COUNT_EN
                        cycle_count <= 16'd0;
`endif
                    end
                end
                RUN: begin
                    pc <= pc_next;
`ifdef CYCLE_COUNT_EN
                    // Counts every RUN cycle, stalls included. Saturates at
                    // 16'hFFFF and stays frozen once in DONE.
                    if (cycle_count != 16'hFFFF) begin
                        cycle_count <= cycle_count + 16'd1;
                    end
`endif
                    if (halt) begin
                        state       <= DONE;
                        fetch_valid <= 1'b0;
                        running     <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    pc          <= START_PC;
                    fetch_valid <= 1'b0;
                    running     <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. A reference model tracks the program
// phase, PC and cycle count using plain integer arithmetic. A compare
// process checks every DUT output against that model on each falling edge.
// Literal checks at key points pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int PC_W   = 10;
    localparam int OFFS_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic              halt = 1'b0;
    logic              stall = 1'b0;
    logic              branch_taken = 1'b0;
    logic              branch_rel = 1'b0;
    logic [OFFS_W-1:0] branch_offs = '0;
    logic [PC_W-1:0]   branch_target = '0;
    logic [PC_W-1:0]   pc;
    logic              fetch_valid;
    logic              running;
    logic              done;
`ifdef CYCLE_COUNT_EN
    logic [15:0]       cycle_count;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .PC_W(PC_W),
        .START_ADDR(0),
        .OFFS_W(OFFS_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .halt(halt),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_rel(branch_rel),
        .branch_offs(branch_offs),
        .branch_target(branch_target),
`ifdef CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .pc(pc),
        .fetch_valid(fetch_valid),
        .running(running),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model. m_phase is 0 for idle, 1 for running, 2 for finished.
    int m_phase = 0;
    int m_pc    = 0;
    int m_cnt   = 0;
    bit m_known = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_pc    = 0;
            m_cnt   = 0;
            m_known = 1'b1;
        end else if (m_phase == 1) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (halt) begin
                m_phase = 2;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (branch_taken) begin
                if (branch_rel) m_pc = (m_pc + int'($signed(branch_offs))) & 32'h3FF;
                else            m_pc = int'(branch_target);
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end else if (req) begin
            m_phase = 1;
            m_pc    = 0;
            m_cnt   = 0;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("pc", 32'(pc), 32'(m_pc));
            check("fetch_valid", 32'(fetch_valid), 32'(m_phase == 1));
            check("running", 32'(running), 32'(m_phase == 1));
            check("done", 32'(done), 32'(m_phase == 2));
`ifdef CYCLE_COUNT_EN
            check("cycle_count", 32'(cycle_count), 32'(m_cnt));
`endif
        end
    end

    // Advance past one rising edge; inputs change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles.
        step();
        step();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_fv", 32'(fetch_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Start the program, then fetch sequentially.
        req = 1'b1;
        step();
        req = 1'b0;
        check("start_pc", 32'(pc), 32'd0);
        check("start_fv", 32'(fetch_valid), 32'd1);
        step();
        check("seq_pc1", 32'(pc), 32'd1);
        step();
        step();
        check("seq_pc3", 32'(pc), 32'd3);
        step();
        step();
        check("seq_pc5", 32'(pc), 32'd5);

        // Relative branch by -3, absolute branch to 0x3FF, then wrap to 0.
        branch_taken = 1'b1;
        branch_rel   = 1'b1;
        branch_offs  = 8'hFD;
        step();
        check("rel_pc", 32'(pc), 32'd2);
        branch_rel    = 1'b0;
        branch_target = 10'h3FF;
        step();
        check("abs_pc", 32'(pc), 32'd1023);
        branch_taken = 1'b0;
        step();
        check("wrap_pc", 32'(pc), 32'd0);

        // Walk to 7, then stall 3 cycles with a branch pending.
        for (int i = 0; i < 7; i++) step();
        check("pre_stall_pc", 32'(pc), 32'd7);
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 10'd100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(pc), 32'd7);
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        step();
        check("post_stall_pc", 32'(pc), 32'd8);

        // Walk to 12, then halt together with stall and branch.
        for (int i = 0; i < 4; i++) step();
        halt         = 1'b1;
        stall        = 1'b1;
        branch_taken = 1'b1;
        step();
        halt         = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        check("halt_pc", 32'(pc), 32'd12);
        check("halt_done", 32'(done), 32'd1);
        check("halt_fv", 32'(fetch_valid), 32'd0);
        step();
        check("done_hold", 32'(done), 32'd1);

        // Restart from DONE.
        req = 1'b1;
        step();
        req = 1'b0;
        check("restart_pc", 32'(pc), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        check("restart_run", 32'(running), 32'd1);

        // A req during RUN must not restart the program.
        for (int i = 0; i < 10; i++) step();
        req = 1'b1;
        step();
        req = 1'b0;
        check("req_in_run_pc", 32'(pc), 32'd11);
        for (int i = 0; i < 9; i++) step();
        check("pre_reset_pc", 32'(pc), 32'd20);

        // Reset in mid-run.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_run", 32'(running), 32'd0);
        check("midrst_fv", 32'(fetch_valid), 32'd0);
        step();
        check("idle_stays", 32'(running), 32'd0);

        // Six RUN cycles including two stalls, the last one a halt.
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        step();
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("cc_done", 32'(done), 32'd1);
        check("cc_halt_pc", 32'(pc), 32'd3);
`ifdef CYCLE_COUNT_EN
        check("cc_total", 32'(cycle_count), 32'd6);
        step();
        check("cc_frozen", 32'(cycle_count), 32'd6);
        req = 1'b1;
        step();
        req = 1'b0;
        check("cc_cleared", 32'(cycle_count), 32'd0);
`endif
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
